// File: rtl/mem_page_reader.sv
// mem_page_reader: drains one page of the paged BRAM into a valid/ready stream, then releases it.
// Optional build macro PAGE_CHECKSUM_EN adds page_csum, the XOR of every word popped for the page.
module mem_page_reader #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int PAGES        = 2,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clkb,
  input  logic                         rstb_n,
  input  logic                         page_rdy,
  input  logic [PAGES/2:0]             page_id,
  input  logic [4:0]                   nent,
  output logic                         page_done,
  output logic [PAGES/2:0]             page_done_id,
  output logic [$clog2(RAM_DEPTH)-1:0] addrb,
  output logic [PAGES/2:0]             pageb,
  output logic                         enb,
  output logic                         regceb,
  input  logic [RAM_WIDTH-1:0]         doutb,
  output logic [RAM_WIDTH-1:0]         m_data,
  output logic                         m_valid,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         busy,
`ifdef PAGE_CHECKSUM_EN
  output logic [RAM_WIDTH-1:0]         page_csum,
`endif
  output logic                         ovf
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = PAGES / 2 + 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int SW = CW + IW;

  // state     | meaning
  // S_IDLE    | waiting for a pending page
  // S_LOAD    | page and count latched, decide empty vs. non-empty
  // S_ISSUE   | issuing reads while credit allows
  // S_DRAIN   | all reads issued, waiting for the stream to empty
  // S_RELEASE | one-cycle page_done
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_RELEASE} state_t;
  state_t r_state, w_next;

  logic                    r_pend_vld;
  logic [PW-1:0]           r_pend_id;
  logic [4:0]              r_pend_nent;
  logic                    r_ovf;
  logic [PW-1:0]           r_page;
  logic [4:0]              r_cnt;
  logic [4:0]              r_addr;
  logic                    r_last_seen;
  logic [READ_LATENCY-1:0] r_vld_sr;
  logic [READ_LATENCY-1:0] r_last_sr;
  logic [IW-1:0]           r_inflight;
  logic [RAM_WIDTH:0]      r_fifo [FIFO_DEPTH];
  logic [FW-1:0]           r_wr_ptr;
  logic [FW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_fifo_cnt;

  logic                    w_take;
  logic [SW-1:0]           w_used;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_push;
  logic                    w_pop;
  logic [RAM_WIDTH:0]      w_head;

  assign w_take       = (r_state == S_IDLE) && r_pend_vld;
  assign w_used       = SW'(r_inflight) + SW'(r_fifo_cnt);
  // Reserving FIFO space at issue time is what makes backpressure lossless.
  assign w_issue      = (r_state == S_ISSUE) && (w_used < SW'(FIFO_DEPTH));
  assign w_issue_last = w_issue && (r_addr == r_cnt - 5'd1);
  assign w_push       = r_vld_sr[READ_LATENCY-1];
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_pop        = m_valid && m_ready;

  assign m_valid = (r_fifo_cnt != '0);
  assign m_data  = m_valid ? w_head[RAM_WIDTH-1:0] : '0;
  assign m_last  = m_valid && w_head[RAM_WIDTH];
  assign ovf     = r_ovf;

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (r_pend_vld) w_next = S_LOAD;
      S_LOAD:    w_next = (r_cnt == 5'd0) ? S_RELEASE : S_ISSUE;
      S_ISSUE:   if (w_issue_last) w_next = S_DRAIN;
      S_DRAIN:   if ((r_inflight == '0) && (r_fifo_cnt == '0) && r_last_seen) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    enb          = w_issue;
    addrb        = '0;
    pageb        = '0;
    page_done    = 1'b0;
    page_done_id = '0;
    busy         = (r_state != S_IDLE);
    regceb       = busy;
    if (w_issue) begin
      addrb = AW'(r_addr);
      pageb = r_page;
    end
    if (r_state == S_RELEASE) begin
      page_done    = 1'b1;
      page_done_id = r_page;
    end
  end

  // The slot frees in the cycle the FSM takes it, so a same-cycle page_rdy still lands.
  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_id   <= '0;
      r_pend_nent <= '0;
      r_ovf       <= 1'b0;
    end else if (page_rdy && (!r_pend_vld || w_take)) begin
      r_pend_vld  <= 1'b1;
      r_pend_id   <= page_id;
      r_pend_nent <= nent;
    end else begin
      if (page_rdy) r_ovf      <= 1'b1;
      if (w_take)   r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_page      <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_last_seen <= 1'b0;
    end else begin
      if (w_take) begin
        r_page <= r_pend_id;
        r_cnt  <= r_pend_nent;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= r_addr + 5'd1;
      end
      if (w_take)                r_last_seen <= 1'b0;
      else if (w_pop && m_last)  r_last_seen <= 1'b1;
    end
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_vld_sr   <= '0;
      r_last_sr  <= '0;
      r_inflight <= '0;
    end else begin
      r_vld_sr[0]  <= w_issue;
      r_last_sr[0] <= w_issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_sr[i]  <= r_vld_sr[i-1];
        r_last_sr[i] <= r_last_sr[i-1];
      end
      case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clkb) begin
    if (w_push) r_fifo[r_wr_ptr] <= {r_last_sr[READ_LATENCY-1], doutb};
  end

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + FW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == FW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + FW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

`ifdef PAGE_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] r_csum_acc;
  logic [RAM_WIDTH-1:0] r_csum;

  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      r_csum_acc <= '0;
      r_csum     <= '0;
    end else begin
      if (w_take)     r_csum_acc <= '0;
      else if (w_pop) r_csum_acc <= r_csum_acc ^ m_data;
      if (r_state == S_RELEASE) r_csum <= r_csum_acc;
    end
  end

  assign page_csum = (r_state == S_RELEASE) ? r_csum_acc : r_csum;
`endif

endmodule

// File: tb/tb_mem_page_reader.sv
// Scoreboard bench for mem_page_reader: a READ_LATENCY=2 instance for most cases, a READ_LATENCY=1
// instance for the full 31-word page.
module tb_mem_page_reader;
  localparam int RW = 18;
  localparam int AW = 10;
  localparam int PW = 2;

  logic clkb = 1'b0;
  always #5 clkb = ~clkb;
  logic rstb_n;

  logic          page_rdy, enb, regceb, page_done, m_valid, m_last, m_ready, busy, ovf;
  logic [PW-1:0] page_id, page_done_id, pageb;
  logic [4:0]    nent;
  logic [AW-1:0] addrb;
  logic [RW-1:0] doutb, m_data;

  logic          page_rdy_1, enb_1, regceb_1, page_done_1, m_valid_1, m_last_1, m_ready_1, busy_1, ovf_1;
  logic [PW-1:0] page_id_1, page_done_id_1, pageb_1;
  logic [4:0]    nent_1;
  logic [AW-1:0] addrb_1;
  logic [RW-1:0] doutb_1, m_data_1;
`ifdef PAGE_CHECKSUM_EN
  logic [RW-1:0] page_csum, page_csum_1;
`endif

  mem_page_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(1024), .PAGES(2), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clkb(clkb), .rstb_n(rstb_n), .page_rdy(page_rdy), .page_id(page_id), .nent(nent),
    .page_done(page_done), .page_done_id(page_done_id), .addrb(addrb), .pageb(pageb),
    .enb(enb), .regceb(regceb), .doutb(doutb), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy),
`ifdef PAGE_CHECKSUM_EN
    .page_csum(page_csum),
`endif
    .ovf(ovf));

  mem_page_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(1024), .PAGES(2), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut_l1 (
    .clkb(clkb), .rstb_n(rstb_n), .page_rdy(page_rdy_1), .page_id(page_id_1), .nent(nent_1),
    .page_done(page_done_1), .page_done_id(page_done_id_1), .addrb(addrb_1), .pageb(pageb_1),
    .enb(enb_1), .regceb(regceb_1), .doutb(doutb_1), .m_data(m_data_1), .m_valid(m_valid_1),
    .m_last(m_last_1), .m_ready(m_ready_1), .busy(busy_1),
`ifdef PAGE_CHECKSUM_EN
    .page_csum(page_csum_1),
`endif
    .ovf(ovf_1));

  // BRAM models: address register then (for latency 2) output register gated by regceb.
  logic [RW-1:0] bram [0:4095];
  logic [RW-1:0] q1, q2, q1_1;
  always @(posedge clkb) begin
    if (enb)    q1   <= bram[{pageb, addrb}];
    if (regceb) q2   <= q1;
    if (enb_1)  q1_1 <= bram[{pageb_1, addrb_1}];
  end
  assign doutb   = q2;
  assign doutb_1 = q1_1;

  int n_chk = 0, n_pass = 0;
  int n_iss = 0, n_pop = 0, n_done = 0, cyc = 0, last_addr_1 = -1;
  logic [RW:0]      q_data[$], q_data1[$];
  logic [PW+AW-1:0] q_iss[$], q_iss1[$];
  logic [PW-1:0]    q_done[$], q_done1[$];
  logic             hold_vld;
  logic [RW-1:0]    hold_data;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  always @(posedge clkb) cyc <= cyc + 1;

  always @(negedge clkb) begin
    if (!rstb_n) hold_vld = 1'b0;
    else begin
      if (enb) begin
        n_iss++;
        if (q_iss.size() == 0) chk("unexpected_enb", 1, 0);
        else chk("issue_addr", {pageb, addrb}, q_iss.pop_front());
        chk("credit_le_fifo_depth", (n_iss - n_pop) <= 4, 1);
      end
      if (hold_vld && m_valid) chk("data_stable_under_bp", m_data, hold_data);
      hold_vld  = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        n_pop++;
        if (q_data.size() == 0) chk("unexpected_word", 1, 0);
        else chk("word", {m_last, m_data}, q_data.pop_front());
      end
      if (page_done) begin
        n_done++;
        if (q_done.size() == 0) chk("unexpected_page_done", 1, 0);
        else chk("page_done_id", page_done_id, q_done.pop_front());
      end
    end
  end

  always @(negedge clkb) begin
    if (rstb_n) begin
      if (enb_1) begin
        last_addr_1 = int'(addrb_1);
        if (q_iss1.size() == 0) chk("l1_unexpected_enb", 1, 0);
        else chk("l1_issue_addr", {pageb_1, addrb_1}, q_iss1.pop_front());
      end
      if (m_valid_1 && m_ready_1) begin
        if (q_data1.size() == 0) chk("l1_unexpected_word", 1, 0);
        else chk("l1_word", {m_last_1, m_data_1}, q_data1.pop_front());
      end
      if (page_done_1) begin
        if (q_done1.size() == 0) chk("l1_unexpected_page_done", 1, 0);
        else chk("l1_page_done_id", page_done_id_1, q_done1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clkb);
    #1;
  endtask

  task automatic expect_page(input logic [PW-1:0] p, input int n, input bit l1);
    for (int a = 0; a < n; a++) begin
      logic [PW+AW-1:0] ia;
      ia = {p, AW'(a)};
      if (l1) begin q_iss1.push_back(ia); q_data1.push_back({a == n - 1, bram[ia]}); end
      else    begin q_iss.push_back(ia);  q_data.push_back({a == n - 1, bram[ia]});  end
    end
    if (l1) q_done1.push_back(p);
    else    q_done.push_back(p);
  endtask

  task automatic send(input logic [PW-1:0] p, input int n, input bit accepted);
    page_rdy = 1'b1; page_id = p; nent = 5'(n);
    if (accepted) expect_page(p, n, 1'b0);
    tick();
    page_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input bit l1, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (!l1 && !busy && q_done.size() == 0 && q_data.size() == 0) begin ok = 1'b1; break; end
      if (l1 && !busy_1 && q_done1.size() == 0 && q_data1.size() == 0) begin ok = 1'b1; break; end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  function automatic longint outs0();
    return {page_done, page_done_id, addrb, pageb, enb, regceb, m_data, m_valid, m_last, busy, ovf};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base, n, t0;
    bit found;
    logic [RW-1:0] x;
    for (int i = 0; i < 4096; i++) bram[i] = RW'(i * 131 + 7);
    bram[1024] = 18'h0A1A1; bram[1025] = 18'h0B2B2; bram[1026] = 18'h0C3C3;
    page_rdy = 0; page_id = 0; nent = 0; m_ready = 0;
    page_rdy_1 = 0; page_id_1 = 0; nent_1 = 0; m_ready_1 = 0;
    rstb_n = 1'b1;
    #2 rstb_n = 1'b0;
    #1 chk("reset_outputs_zero", outs0(), 0);
`ifdef PAGE_CHECKSUM_EN
    chk("reset_csum_zero", page_csum, 0);
`endif
    tick(); tick();
    rstb_n = 1'b1;
    tick();

    // Page 1, three words, no backpressure
    m_ready = 1'b1;
    send(1, 3, 1'b1);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin @(negedge clkb); found = enb; end
    chk("t1_enb_seen", found, 1);
    t0 = cyc;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin if (m_valid) found = 1; else @(negedge clkb); end
    chk("t1_first_valid_latency", cyc - t0, 3);
    n = 0;
    while (m_valid && n < 10) begin n++; @(negedge clkb); end
    chk("t1_words_contiguous", n, 3);
    wait_idle("t1_idle", 1'b0, 20);
    chk("t1_issue_count", n_iss, 3);
`ifdef PAGE_CHECKSUM_EN
    chk("t1_csum", page_csum, 18'h0A1A1 ^ 18'h0B2B2 ^ 18'h0C3C3);
`endif

    // Backpressure: stall after the first word
    base = n_iss;
    send(0, 8, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clkb); found = m_valid; end
    chk("t2_first_valid", found, 1);
    @(posedge clkb); #1 m_ready = 1'b0;
    repeat (10) tick();
    chk("t2_issue_stops_at_credit", n_iss - base, 5);
    chk("t2_valid_held", m_valid, 1);
    for (int k = 0; k < 100 && (busy || q_done.size() != 0); k++) begin m_ready = ~m_ready; tick(); end
    m_ready = 1'b1;
    wait_idle("t2_idle", 1'b0, 20);
    chk("t2_issue_total", n_iss - base, 8);

    // Empty page
    base = n_iss;
    send(0, 0, 1'b1);
    found = 0;
    for (int k = 0; k < 3 && !found; k++) begin @(negedge clkb); found = page_done; end
    chk("t3_done_within_3", found, 1);
    wait_idle("t3_idle", 1'b0, 10);
    chk("t3_no_enb", n_iss - base, 0);
`ifdef PAGE_CHECKSUM_EN
    chk("t3_csum_zero", page_csum, 0);
`endif

    // Overflow of the pending slot
    chk("t4_ovf_clear_before", ovf, 0);
    send(0, 2, 1'b1);
    send(1, 1, 1'b1);
    send(0, 3, 1'b0);
    #1 chk("t4_ovf_set", ovf, 1);
    wait_idle("t4_idle", 1'b0, 40);
    chk("t4_ovf_sticky", ovf, 1);

    // Reset in the middle of a 31-word page
    base = n_pop;
    send(1, 31, 1'b1);
    for (int k = 0; k < 100 && (n_pop - base) < 5; k++) tick();
    chk("t5_five_words", (n_pop - base) >= 5, 1);
    @(posedge clkb); #1 rstb_n = 1'b0;
    #1 chk("t5_outputs_zero_in_reset", outs0(), 0);
    q_data.delete(); q_iss.delete(); q_done.delete();
    n_iss = 0; n_pop = 0; base = n_done;
    tick(); tick();
    rstb_n = 1'b1;
    repeat (5) tick();
    chk("t5_no_page_done", n_done - base, 0);
`ifdef PAGE_CHECKSUM_EN
    chk("t5_csum_zero_after_reset", page_csum, 0);
`endif
    send(0, 3, 1'b1);
    wait_idle("t5_recover_idle", 1'b0, 30);
    chk("t5_recover_pops", n_pop, 3);

    // READ_LATENCY=1 instance, full 31-word page
    m_ready_1 = 1'b1;
    page_rdy_1 = 1'b1; page_id_1 = 2'd1; nent_1 = 5'd31;
    expect_page(2'd1, 31, 1'b1);
    tick();
    page_rdy_1 = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin @(negedge clkb); found = m_valid_1; end
    chk("t6_first_valid", found, 1);
    n = 0;
    while (m_valid_1 && n < 40) begin n++; @(negedge clkb); end
    chk("t6_back_to_back", n, 31);
    wait_idle("t6_idle", 1'b1, 20);
    chk("t6_last_addr", last_addr_1, 30);
`ifdef PAGE_CHECKSUM_EN
    x = '0;
    for (int a = 0; a < 31; a++) x = x ^ bram[1024 + a];
    chk("t6_csum", page_csum_1, x);
`endif

    chk("all_queues_empty", q_data.size() + q_data1.size() + q_iss.size() + q_iss1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_page_reader.md
Name: mem_page_reader

Overview:
- Read-side controller for the paged dual-port BRAM.
- Takes a "page ready" notice (page index plus entry count) from the write side and issues sequential reads of that page on the BRAM read port.
- Allows for the BRAM's fixed read latency and presents the words as a valid/ready stream with a last marker.
- Hands the page back to the writer once it has been fully drained.

Parameters:
- RAM_WIDTH, 18, data word width; matches the BRAM.
- RAM_DEPTH, 1024, entries per page; address width is clogb2(RAM_DEPTH).
- PAGES, 2, page count; page index width is PAGES/2+1.
- READ_LATENCY, 2, BRAM read latency in cycles: 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- FIFO_DEPTH, 4, output buffer depth; must be at least READ_LATENCY+1.

Ports:
- clkb  in  1  single clock for all logic.
- rstb_n  in  1  asynchronous reset, active-low.
- page_rdy  in  1  one-cycle pulse: a page has been filled.
- page_id  in  PAGES/2+1  page index, qualified by page_rdy.
- nent  in  5  entries in that page (0..31), qualified by page_rdy.
- page_done  out  1  one-cycle pulse: the page is released back to the writer.
- page_done_id  out  PAGES/2+1  index of the released page, valid with page_done.
- addrb  out  clogb2(RAM_DEPTH)  BRAM read address.
- pageb  out  PAGES/2+1  BRAM read page.
- enb  out  1  BRAM read enable; high only on issue cycles.
- regceb  out  1  BRAM output register enable.
- doutb  in  RAM_WIDTH  BRAM read data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  marks the final word of the page.
- m_ready  in  1  stream ready from the consumer.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky: a page_rdy was dropped.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending slot empty, FIFO empty, in-flight count 0. Reset mid-drain abandons the page with no page_done.
- Pending slot (1 entry):
  - page_rdy loads page_id and nent when the slot is empty.
  - page_rdy while the slot is full: request dropped, ovf set until reset.
  - The slot is freed the cycle the FSM takes it, so a page_rdy in that same cycle is accepted.
- State IDLE → LOAD when the pending slot is valid:
  - latch page and count.
  - address counter = 0.
- LOAD:
  - count == 0 → RELEASE.
  - otherwise → ISSUE.
- ISSUE:
  - Issue a read when in_flight + fifo_count < FIFO_DEPTH: enb=1, addrb=counter, pageb=page; then counter++.
  - After issuing address count-1, go to DRAIN.
- DRAIN: wait until in_flight == 0, the FIFO is empty, and the last word has been accepted (m_valid & m_ready & m_last), then go to RELEASE.
- RELEASE: page_done=1 and page_done_id=page for exactly one cycle, then → IDLE.
- Latency tracking:
  - A READ_LATENCY-deep valid shift register is loaded with enb.
  - When its tail bit is set, doutb is written into the FIFO the same cycle.
  - regceb = 1 whenever busy.
  - Credit accounting guarantees the FIFO never overflows, so no data is ever lost under backpressure.
- Stream:
  - m_valid = FIFO not empty; m_data = FIFO head; the head pops on m_valid & m_ready.
  - m_data is stable while m_valid is high and m_ready is low.
  - m_last is set on the word from address count-1.
- Throughput: 1 word/cycle with m_ready held high. First m_valid appears READ_LATENCY+1 cycles after the first enb, counting the FIFO write cycle.
- Address arithmetic:
  - The counter is 5 bits wide internally and zero-extended to the addrb width.
  - nent ≤ 31 < RAM_DEPTH, so addresses never wrap.
- Simultaneous FIFO push and pop: both happen; occupancy is unchanged.

Optional Feature:
- PAGE_CHECKSUM_EN defined:
  - Adds output page_csum [RAM_WIDTH-1:0], the XOR of every word popped for the page.
  - page_csum is valid with page_done and holds until the next page_done.
  - It is 0 for a page with nent=0 and 0 after reset.
- Not defined: the port and its logic are absent.

Test Plan:
- Page 1, nent=3, BRAM[1024..1026]=A,B,C, m_ready=1:
  - enb high for 3 cycles at addrb 0,1,2 with pageb=1.
  - m_data sequence A,B,C on consecutive cycles, m_last only with C.
  - Then page_done=1 with page_done_id=1.
- Backpressure: nent=8, m_ready=0 after the first word:
  - enb stops once in_flight + fifo_count = 4.
  - Toggle m_ready 1/0: all 8 words delivered in order, no duplicates or losses.
- nent=0 on page 0: no enb and no m_valid; page_done pulses within 3 cycles.
- Overflow: page_rdy for page 0 (nent=2), then page 1 and page 0 while the pending slot is full:
  - the third request is dropped and ovf=1.
  - page 0 and page 1 complete in that order.
- Reset mid-drain: assert rstb_n=0 after 5 of 31 words:
  - all outputs go to 0 immediately, no page_done.
  - A new page_rdy afterwards drains normally.
- nent=31 with READ_LATENCY=1 and m_ready=1:
  - 31 words back-to-back, last address 30, m_last on the 31st word.
  - With PAGE_CHECKSUM_EN defined, page_csum equals the XOR of the 31 words.
